// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared types, default geometry and width helpers for the
//            direct-mapped instruction cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REFILL = 3'd2,
    RESP   = 3'd3,
    FLUSH  = 3'd4
  } icache_state_t;

  // Default cache geometry
  localparam int c_ICACHE_NUM_LINES = 16;
  localparam int c_ICACHE_WPL       = 4;
  localparam int c_ICACHE_ADDR_W    = 32;

  // Word-offset width inside a line
  function automatic int icache_off_w(input int wpl);
    return $clog2(wpl);
  endfunction

  // Line-index width
  function automatic int icache_idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag width: everything above index, offset and the 2 byte bits
  function automatic int icache_tag_w(input int addr_w, input int num_lines, input int wpl);
    return addr_w - icache_idx_w(num_lines) - icache_off_w(wpl) - 2;
  endfunction

  localparam int c_ICACHE_OFF_W = icache_off_w(c_ICACHE_WPL);
  localparam int c_ICACHE_IDX_W = icache_idx_w(c_ICACHE_NUM_LINES);
  localparam int c_ICACHE_TAG_W = icache_tag_w(c_ICACHE_ADDR_W, c_ICACHE_NUM_LINES, c_ICACHE_WPL);

endpackage
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_tag_array
// Purpose  : Valid/tag/data storage for the instruction cache. Combinational
//            read port, single-word write port, single-cycle invalidate-all.
// Revision : 1.0 - initial release
// ============================================================================
module icache_tag_array #(
  parameter int IDX_W = 4,
  parameter int OFF_W = 2,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_index,
  input  logic [OFF_W-1:0] i_rd_offset,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic             i_wr_en,
  input  logic [OFF_W-1:0] i_wr_offset,
  input  logic [31:0]      i_wr_data,
  input  logic             i_set_valid,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_flush_all
);

  localparam int c_LINES = 1 << IDX_W;
  localparam int c_WPL   = 1 << OFF_W;

  logic [c_LINES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [c_LINES];
  logic [31:0]        r_data [c_LINES][c_WPL];

  // Valid bits: cleared by reset or flush, set when the last refill beat lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flush_all) begin
      r_valid <= '0;
    end else if (i_wr_en && i_set_valid) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Data and tag storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_index][i_wr_offset] <= i_wr_data;
      if (i_set_valid) begin
        r_tag[i_index] <= i_wr_tag;
      end
    end
  end

  assign o_rd_valid = r_valid[i_index];
  assign o_rd_tag   = r_tag[i_index];
  assign o_rd_data  = r_data[i_index][i_rd_offset];

endmodule
`default_nettype wire

// File: rtl/instr_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_ctrl
// Purpose  : Direct-mapped instruction-cache controller between IF and
//            instruction memory. 1-cycle hit, beat-wise refill on miss,
//            whole-cache invalidate on flush.
// Options  : ICACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cache_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = c_ICACHE_NUM_LINES,
  parameter int WORDS_PER_LINE = c_ICACHE_WPL,
  parameter int ADDR_W         = c_ICACHE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              stall,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int c_OFF_W = icache_off_w(WORDS_PER_LINE);
  localparam int c_IDX_W = icache_idx_w(NUM_LINES);
  localparam int c_TAG_W = icache_tag_w(ADDR_W, NUM_LINES, WORDS_PER_LINE);
  localparam logic [c_OFF_W-1:0] c_LAST_BEAT = '1;

  icache_state_t       r_state;
  logic [ADDR_W-3:0]   r_pc;          // word address of the fetch in flight
  logic [c_OFF_W-1:0]  r_beat;
  logic                r_flush_pend;  // flush seen mid-beat, honoured at the ack

  logic [c_OFF_W-1:0]  w_off;
  logic [c_IDX_W-1:0]  w_idx;
  logic [c_TAG_W-1:0]  w_tag;
  logic                w_rd_valid;
  logic [c_TAG_W-1:0]  w_rd_tag;
  logic [31:0]         w_rd_data;
  logic                w_tag_match;
  logic                w_hit;
  logic                w_miss;
  logic                w_wr_en;
  logic                w_set_valid;
  logic                w_unused;

  assign w_unused    = ^fetch_pc[1:0];
  assign w_off       = r_pc[c_OFF_W-1:0];
  assign w_idx       = r_pc[c_OFF_W +: c_IDX_W];
  assign w_tag       = r_pc[ADDR_W-3 -: c_TAG_W];
  assign w_tag_match = w_rd_valid && (w_rd_tag == w_tag);
  assign w_hit       = (r_state == LOOKUP) && w_tag_match;
  assign w_miss      = (r_state == LOOKUP) && !w_tag_match;

  // A line becomes valid only when its final beat lands with no flush pending
  assign w_wr_en     = (r_state == REFILL) && mem_ack;
  assign w_set_valid = (r_beat == c_LAST_BEAT) && !flush && !r_flush_pend;

  icache_tag_array #(
    .IDX_W (c_IDX_W),
    .OFF_W (c_OFF_W),
    .TAG_W (c_TAG_W)
  ) u_tag_array (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_idx),
    .i_rd_offset (w_off),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_wr_en),
    .i_wr_offset (r_beat),
    .i_wr_data   (mem_rdata),
    .i_set_valid (w_set_valid),
    .i_wr_tag    (w_tag),
    .i_flush_all (r_state == FLUSH)
  );

  // Controller FSM: accept fetches, refill on miss, invalidate on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state <= FLUSH;
          end else if (fetch_req) begin
            r_pc    <= fetch_pc[ADDR_W-1:2];
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) begin
            r_state <= FLUSH;
          end else if (w_tag_match) begin
            // Hit: a new request this cycle keeps the pipeline streaming
            if (fetch_req) begin
              r_pc <= fetch_pc[ADDR_W-1:2];
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_beat <= r_beat + 1'b1;
            if (flush || r_flush_pend) begin
              r_flush_pend <= 1'b0;
              r_beat       <= '0;
              r_state      <= FLUSH;
            end else if (r_beat == c_LAST_BEAT) begin
              r_state <= RESP;
            end
          end else if (flush) begin
            // Never drop mem_req mid-beat; finish this handshake first
            r_flush_pend <= 1'b1;
          end
        end
        RESP:    r_state <= flush ? FLUSH : IDLE;
        FLUSH:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so an async reset drops them at once
  assign fetch_valid = (w_hit && !flush) || (r_state == RESP);
  assign fetch_instr = fetch_valid ? w_rd_data : 32'd0;
  assign stall       = (r_state == REFILL) || (r_state == FLUSH) ||
                       ((r_state == LOOKUP) && (!w_tag_match || flush));
  assign mem_req     = (r_state == REFILL);
  assign mem_addr    = mem_req ? {w_tag, w_idx, r_beat, 2'b00} : '0;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating lookup statistics; only reset clears them, flush does not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_cache_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_instr_cache_ctrl
// Purpose  : Scoreboard bench for instr_cache_ctrl. Stimulus pushes expected
//            instruction words and refill beat addresses; monitors pop them.
//            Memory word at address A is 32'hC0DE_0000 | A[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  instr_cache_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .stall       (stall),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
`endif
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int resp_cnt  = 0;
  int ack_cnt   = 0;
  int stall_cnt = 0;
  int mreq_cnt  = 0;
  int cyc       = 0;
  int          resp_cyc[$];
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Output monitor: pops an expected word for every fetch_valid pulse
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (stall)   stall_cnt++;
        if (mem_req) mreq_cnt++;
        if (fetch_valid) begin
          resp_cnt++;
          resp_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_fetch_valid: got instr 0x%08h expected no response", fetch_instr);
          end else begin
            chk("fetch_instr", fetch_instr, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Memory model: acks each beat in its second cycle, checks beat addresses
  initial begin
    int          wait_cnt;
    logic [31:0] beat_addr;
    wait_cnt  = 0;
    beat_addr = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) beat_addr = mem_addr;
        if (wait_cnt == 1) begin
          chk("mem_addr_stable", mem_addr, beat_addr);
          if (addr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_mem_beat: got addr 0x%08h expected no request", mem_addr);
          end else begin
            chk("mem_addr", mem_addr, addr_q.pop_front());
          end
          mem_ack   = 1'b1;
          mem_rdata = 32'hC0DE_0000 | {16'h0000, mem_addr[15:0]};
          ack_cnt++;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 200 && resp_cnt < target; i++) @(posedge clk);
    chk("resp_count", 32'(resp_cnt), 32'(target));
    @(negedge clk);
  endtask

  task automatic fetch1(input logic [31:0] pc, input logic [31:0] exp);
    int n0;
    n0 = resp_cnt;
    exp_q.push_back(exp);
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    @(negedge clk);
    fetch_req = 1'b0;
    wait_resp(n0 + 1);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_acks(input int target);
    for (int i = 0; i < 200 && ack_cnt < target; i++) @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
    chk({tag, "_stall"},       {31'd0, stall},       32'd0);
    chk({tag, "_mem_req"},     {31'd0, mem_req},     32'd0);
    chk({tag, "_mem_addr"},    mem_addr,             32'd0);
    chk({tag, "_fetch_instr"}, fetch_instr,          32'd0);
`ifdef ICACHE_PERF_CNT_EN
    chk({tag, "_hit_cnt"},     hit_cnt,              32'd0);
    chk({tag, "_miss_cnt"},    miss_cnt,             32'd0);
`endif
  endtask

  initial begin
    int a0;
    int r0;
    int s0;
    int m0;
    rst       = 1'b1;
    fetch_req = 1'b0;
    fetch_pc  = 32'd0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cold miss on 0x40: four beats, stall through LOOKUP + 8 refill cycles
    a0 = ack_cnt;
    s0 = stall_cnt;
    push_line(32'h40);
    fetch1(32'h40, 32'hC0DE_0040);
    chk("cold_acks", 32'(ack_cnt - a0), 32'd4);
    chk("cold_stall_cycles", 32'(stall_cnt - s0), 32'd9);

    // Back-to-back hits on the resident line
    r0 = resp_cnt;
    m0 = mreq_cnt;
    exp_q.push_back(32'hC0DE_0044);
    exp_q.push_back(32'hC0DE_0048);
    exp_q.push_back(32'hC0DE_004C);
    @(negedge clk); fetch_req = 1'b1; fetch_pc = 32'h44;
    @(negedge clk); fetch_pc = 32'h48;
    @(negedge clk); fetch_pc = 32'h4C;
    @(negedge clk); fetch_req = 1'b0;
    wait_resp(r0 + 3);
    chk("stream_mem_req", 32'(mreq_cnt - m0), 32'd0);
    if (resp_cyc.size() >= 3) begin
      chk("stream_consecutive",
          32'(resp_cyc[resp_cyc.size()-1] - resp_cyc[resp_cyc.size()-3]), 32'd2);
    end

    // Flush in IDLE, then conflict eviction 0x40 / 0x140 / 0x40
    pulse_flush();
    a0 = ack_cnt;
    push_line(32'h40);
    fetch1(32'h40, 32'hC0DE_0040);
    push_line(32'h140);
    fetch1(32'h140, 32'hC0DE_0140);
    push_line(32'h40);
    fetch1(32'h40, 32'hC0DE_0040);
    chk("conflict_acks", 32'(ack_cnt - a0), 32'd12);

    // Flush during beat 1 of the 0x80 refill
    a0 = ack_cnt;
    r0 = resp_cnt;
    addr_q.push_back(32'h80);
    addr_q.push_back(32'h84);
    @(negedge clk); fetch_req = 1'b1; fetch_pc = 32'h80;
    @(negedge clk); fetch_req = 1'b0;
    wait_acks(a0 + 1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (6) @(negedge clk);
    chk("flush_refill_acks", 32'(ack_cnt - a0), 32'd2);
    chk("flush_refill_no_resp", 32'(resp_cnt), 32'(r0));
    chk("flush_refill_mem_req", {31'd0, mem_req}, 32'd0);
    a0 = ack_cnt;
    push_line(32'h80);
    fetch1(32'h80, 32'hC0DE_0080);
    chk("refetch_80_acks", 32'(ack_cnt - a0), 32'd4);

    // Reset during beat 2 of the 0xC0 refill
    a0 = ack_cnt;
    addr_q.push_back(32'hC0);
    addr_q.push_back(32'hC4);
    @(negedge clk); fetch_req = 1'b1; fetch_pc = 32'hC0;
    @(negedge clk); fetch_req = 1'b0;
    wait_acks(a0 + 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_mem_req_same_cycle", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midrst");
    @(negedge clk);
    push_line(32'hC0);
    fetch1(32'hC0, 32'hC0DE_00C0);
    chk("after_rst_acks", 32'(ack_cnt - a0), 32'd6);

    // Hits on the refilled line; 1 miss + 3 hits since the reset
    m0 = mreq_cnt;
    fetch1(32'hC4, 32'hC0DE_00C4);
    fetch1(32'hC8, 32'hC0DE_00C8);
    fetch1(32'hCC, 32'hC0DE_00CC);
    chk("hits_c0_mem_req", 32'(mreq_cnt - m0), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
    chk("perf_hit_cnt",  hit_cnt,  32'd3);
    chk("perf_miss_cnt", miss_cnt, 32'd1);
    pulse_flush();
    chk("perf_hit_cnt_flush",  hit_cnt,  32'd3);
    chk("perf_miss_cnt_flush", miss_cnt, 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_empty",  32'(exp_q.size()),  32'd0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
